// File: rtl/sail_clk_pkg.sv
// Shared clocking/reset definitions: sequencer state encoding and default
// qualification timings used by the PLL reset sequencer.
package sail_clk_pkg;

   // Sequencer states; the numeric values are visible on the debug port.
   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABILIZE = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } seq_state_e;

   // Consecutive synchronized-lock cycles before the reset hold begins.
   localparam int unsigned DEF_LOCK_CYCLES = 1024;
   // Cycles the core reset stays asserted once lock has qualified.
   localparam int unsigned DEF_HOLD_CYCLES = 16;

   // Width of the shared phase counter and of the lock-loss event counter.
   localparam int unsigned SEQ_CNT_W  = 16;
   localparam int unsigned LOST_CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
      logic [LOST_CNT_W-1:0] res;
      res = v;
      if (v != {LOST_CNT_W{1'b1}}) begin
         res = v + {{(LOST_CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a full cycle to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: waits for a stable PLL lock, holds the core reset for
// a fixed number of cycles, then releases it. Runs on the free-running board
// clock so it keeps working while the PLL output is absent or unstable.
module pll_reset_sequencer
   import sail_clk_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       locked,
   input  logic       sw_reset_req,
   output logic       core_rst_n,
   output logic       pll_ready,
   output logic       lock_lost,
   output logic [7:0] lock_lost_count,
   output logic [1:0] state
);

   // Terminal counter values for the two timed phases.
   localparam logic [SEQ_CNT_W-1:0] LOCK_LAST = SEQ_CNT_W'(LOCK_CYCLES - 1);
   localparam logic [SEQ_CNT_W-1:0] HOLD_LAST = SEQ_CNT_W'(HOLD_CYCLES - 1);
   localparam logic [SEQ_CNT_W-1:0] CNT_ONE   = SEQ_CNT_W'(1);

   logic                  locked_s;

   seq_state_e            state_q,      state_d;
   logic [SEQ_CNT_W-1:0]  cnt_q,        cnt_d;
   logic                  lost_q,       lost_d;
   logic [LOST_CNT_W-1:0] lost_cnt_q,   lost_cnt_d;
   logic                  core_rst_n_q;
   logic                  ready_q;

   // The raw lock flag is only ever used through this synchronizer.
   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   // Next-state logic; the counter is cleared on every state change, and in
   // the timed phases it stops at its terminal value so it can never wrap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lost_d     = 1'b0;
      lost_cnt_d = lost_cnt_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABILIZE;
               cnt_d   = '0;
            end
         end
         ST_STABILIZE: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            // Lock loss wins over a software reset request in the same cycle.
            if (!locked_s) begin
               state_d    = ST_WAIT_LOCK;
               cnt_d      = '0;
               lost_d     = 1'b1;
               lost_cnt_d = sat_inc(lost_cnt_q);
            end else if (sw_reset_req) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counters and outputs; the reset outputs follow the next state so
   // they change on the very edge the FSM enters or leaves RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT_LOCK;
         cnt_q        <= '0;
         lost_q       <= 1'b0;
         lost_cnt_q   <= '0;
         core_rst_n_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lost_q       <= lost_d;
         lost_cnt_q   <= lost_cnt_d;
         core_rst_n_q <= (state_d == ST_RUN);
         ready_q      <= (state_d == ST_RUN);
      end
   end

   assign core_rst_n      = core_rst_n_q;
   assign pll_ready       = ready_q;
   assign lock_lost       = lost_q;
   assign lock_lost_count = lost_cnt_q;
   assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with LOCK_CYCLES=8, HOLD_CYCLES=4.
// Every change of the output tuple is matched, with its edge number, against
// the next entry of an expected-event queue filled by the stimulus process.
module tb_pll_reset_sequencer;

   localparam int W = 29; // {edge[15:0], state[1:0], core_rst_n, pll_ready, lock_lost, count[7:0]}
   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;
   localparam logic [12:0] RST_OUT = 13'd0;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       locked;
   logic       sw_reset_req;
   logic       core_rst_n;
   logic       pll_ready;
   logic       lock_lost;
   logic [7:0] lock_lost_count;
   logic [1:0] state;

   always #5 clk = ~clk;

   // Edge number since the last reset release.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   pll_reset_sequencer #(
      .LOCK_CYCLES (8),
      .HOLD_CYCLES (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .locked          (locked),
      .sw_reset_req    (sw_reset_req),
      .core_rst_n      (core_rst_n),
      .pll_ready       (pll_ready),
      .lock_lost       (lock_lost),
      .lock_lost_count (lock_lost_count),
      .state           (state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [7:0]   exp_cnt = 8'd0;
   logic         mon_en;
   logic [12:0]  mon_prev;
   logic [12:0]  mon_cur;
   logic [W-1:0] mon_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_event(input int c, input logic [1:0] st, input logic ll);
      logic up;
      up = (st == S3);
      exp_q.push_back({16'(c), st, up, up, ll, exp_cnt});
   endtask

   // locked rose at the negedge after edge c: 2 sync edges + 1 FSM edge,
   // then 8 STABILIZE cycles and 4 HOLD cycles.
   task automatic exp_relock(input int c, input bit to_run);
      exp_event(c + 3, S1, 1'b0);
      exp_event(c + 11, S2, 1'b0);
      if (to_run) exp_event(c + 15, S3, 1'b0);
   endtask

   // locked fell at the negedge after edge c while in RUN.
   task automatic exp_loss(input int c);
      exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      exp_event(c + 3, S0, 1'b1);
      exp_event(c + 4, S0, 1'b0);
   endtask

   task automatic drained(input string name);
      check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check_all_reset(input string name);
      check({name, "_state"},      64'(state),           64'd0);
      check({name, "_core_rst_n"}, 64'(core_rst_n),      64'd0);
      check({name, "_pll_ready"},  64'(pll_ready),       64'd0);
      check({name, "_lock_lost"},  64'(lock_lost),       64'd0);
      check({name, "_count"},      64'(lock_lost_count), 64'd0);
   endtask

   // Asserts rst_n between clock edges and checks the outputs before any edge.
   task automatic async_reset(input string name);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_reset(name);
      @(negedge clk);
      locked = 1'b0;
      exp_cnt = 8'd0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   // Monitor: any change of the outputs must be the next expected event.
   always @(negedge clk) begin
      if (!mon_en) begin
         mon_prev = RST_OUT;
      end else begin
         mon_cur = {state, core_rst_n, pll_ready, lock_lost, lock_lost_count};
         if (mon_cur !== mon_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: actual edge=%0d out=0x%0h required no change", cyc, mon_cur);
            end else begin
               mon_exp = exp_q.pop_front();
               check($sformatf("event_edge%0d", mon_exp[W-1:13]), 64'({16'(cyc), mon_cur}), 64'(mon_exp));
            end
            mon_prev = mon_cur;
         end
      end
   end

   // ---------------- driver / stimulus ----------------
   initial begin
      int c;
      rst_n        = 1'b0;
      locked       = 1'b0;
      sw_reset_req = 1'b0;
      mon_en       = 1'b0;
      repeat (3) @(negedge clk);
      check_all_reset("reset");

      // Release with lock already present before edge 1.
      rst_n  = 1'b1;
      locked = 1'b1;
      mon_en = 1'b1;
      exp_relock(0, 1'b1);
      wait_until(18);
      drained("first_lock");

      // Software reset in RUN: core reset low for exactly 4 cycles.
      c = cyc;
      sw_reset_req = 1'b1;
      exp_event(c + 1, S2, 1'b0);
      exp_event(c + 5, S3, 1'b0);
      @(negedge clk);
      sw_reset_req = 1'b0;
      wait_until(c + 8);
      drained("sw_reset_run");

      // Reset mid-RUN drops core_rst_n immediately.
      async_reset("reset_in_run");

      // Lock glitch during STABILIZE, then relock with full latency.
      c = cyc;
      locked = 1'b1;
      exp_event(c + 3, S1, 1'b0);
      wait_until(c + 6);
      locked = 1'b0;
      exp_event(c + 9, S0, 1'b0);
      wait_until(c + 9);
      locked = 1'b1;
      exp_relock(c + 9, 1'b1);
      wait_until(c + 27);
      drained("stabilize_glitch");
      check("stabilize_glitch_count", 64'(lock_lost_count), 64'd0);

      // Lock loss in RUN.
      c = cyc;
      locked = 1'b0;
      exp_loss(c);
      wait_until(c + 6);
      drained("loss_in_run");

      // Software reset request in WAIT_LOCK is ignored.
      sw_reset_req = 1'b1;
      @(negedge clk);
      sw_reset_req = 1'b0;
      repeat (6) @(negedge clk);
      drained("sw_reset_wait");
      check("sw_reset_wait_state", 64'(state), 64'(S0));

      // Software reset and lock loss seen in the same cycle.
      c = cyc;
      locked = 1'b1;
      exp_relock(c, 1'b1);
      wait_until(c + 17);
      c = cyc;
      locked = 1'b0;
      exp_loss(c);
      wait_until(c + 2);
      sw_reset_req = 1'b1;
      @(negedge clk);
      sw_reset_req = 1'b0;
      wait_until(c + 6);
      drained("sw_and_loss");

      // 260 more lock losses: the event counter must stick at 255.
      for (int i = 0; i < 260; i++) begin
         c = cyc;
         locked = 1'b1;
         exp_relock(c, 1'b1);
         wait_until(c + 16);
         c = cyc;
         locked = 1'b0;
         exp_loss(c);
         wait_until(c + 5);
      end
      drained("saturation");
      check("saturation_count", 64'(lock_lost_count), 64'd255);

      // Reset asserted mid-HOLD clears everything without a clock edge.
      c = cyc;
      locked = 1'b1;
      exp_relock(c, 1'b0);
      wait_until(c + 13);
      drained("reach_hold");
      async_reset("reset_in_hold");
      repeat (5) @(negedge clk);
      drained("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
